// File: rtl/mem_pkg.sv
// Shared encodings for the byte-serial multi-port memory controller.
// Size codes, FSM states, IO region tag and byte-count helper.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } sz_e;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_e;

  localparam logic [1:0] IO_REG = 2'b11;

  // sz 11 is treated as a word
  function automatic logic [2:0] nbytes(input logic [1:0] sz);
    unique case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read return pipe: tracks issued read bytes for RD_LAT edges,
// assembles returning bytes into lanes and extends the result.
module mem_rd_pipe
  import mem_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic [1:0]  push_idx,
  input  logic        push_last,
  input  logic [1:0]  sz,
  input  logic        sext,
  input  logic [7:0]  mem_din,
  output logic        fin,
  output logic [31:0] rdata
);

  logic [RD_LAT-1:0] v;
  logic [RD_LAT-1:0] lst;
  logic [1:0]        ix [RD_LAT];
  logic [31:0]       lanes;
  logic [31:0]       merged;
  logic              cap;

  assign cap = v[RD_LAT-1] & ~flush;
  assign fin = cap & lst[RD_LAT-1];

  always_comb begin
    merged = lanes;
    merged[{ix[RD_LAT-1], 3'b000} +: 8] = mem_din;
  end

  function automatic logic [31:0] ext(
    input logic [31:0] m,
    input logic [1:0]  s,
    input logic        sx
  );
    unique case (nbytes(s))
      3'd1:    return {{24{sx & m[7]}}, m[7:0]};
      3'd2:    return {{16{sx & m[15]}}, m[15:0]};
      default: return m;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      v     <= '0;
      lst   <= '0;
      lanes <= '0;
      rdata <= '0;
      for (int k = 0; k < RD_LAT; k++) ix[k] <= '0;
    end else begin
      v[0]   <= push & ~flush;
      ix[0]  <= push_idx;
      lst[0] <= push_last;
      for (int k = 1; k < RD_LAT; k++) begin
        v[k]   <= v[k-1] & ~flush;
        ix[k]  <= ix[k-1];
        lst[k] <= lst[k-1];
      end
      if (cap) lanes <= merged;
      if (fin) rdata <= ext(merged, sz, sext);
    end
  end

endmodule

// File: rtl/mem_ctrl_mp.sv
// Multi-port byte-serial RAM controller: fixed-priority arbiter,
// issue FSM and write path; read returns go through mem_rd_pipe.
module mem_ctrl_mp
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NPORT  = 3,
  parameter int RD_LAT = 2,
  parameter int IO_LSB = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORT-1:0]        req,
  input  logic [NPORT-1:0]        we,
  input  logic [3*NPORT-1:0]      size,
  input  logic [ADDR_W*NPORT-1:0] addr,
  input  logic [32*NPORT-1:0]     wdata,
  output logic [31:0]             rdata,
  output logic [NPORT-1:0]        done,
  output logic                    busy,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  state_e state, state_n;

  logic [2:0]        g, sel, dsel, cnt, cur_cnt, cur_n, n_l;
  logic [2:0]        size_s;
  logic [1:0]        sz_l;
  logic              we_l, sext_l, we_s, req_g, any, idle;
  logic              cur_we, io, abort, issue, stall, fire;
  logic              last, wr_last, rd_fin;
  logic [ADDR_W-1:0] addr_l, addr_s, addr_g, cur_addr, baddr;
  logic [31:0]       wdata_l, wdata_s, cur_wd;
  logic [NPORT-1:0]  done_n;

  // lowest index wins; also pick out the granted port's live inputs
  always_comb begin
    any     = 1'b0;
    sel     = '0;
    req_g   = 1'b0;
    addr_g  = '0;
    we_s    = 1'b0;
    size_s  = '0;
    addr_s  = '0;
    wdata_s = '0;
    for (int p = NPORT - 1; p >= 0; p--) begin
      if (req[p]) begin
        any = 1'b1;
        sel = 3'(p);
      end
    end
    for (int p = 0; p < NPORT; p++) begin
      if (g == 3'(p)) begin
        req_g  = req[p];
        addr_g = addr[ADDR_W*p +: ADDR_W];
      end
      if (sel == 3'(p)) begin
        we_s    = we[p];
        size_s  = size[3*p +: 3];
        addr_s  = addr[ADDR_W*p +: ADDR_W];
        wdata_s = wdata[32*p +: 32];
      end
    end
  end

  assign idle     = (state == IDLE);
  assign n_l      = nbytes(sz_l);
  assign cur_we   = idle ? we_s : we_l;
  assign cur_n    = idle ? nbytes(size_s[1:0]) : n_l;
  assign cur_addr = idle ? addr_s : addr_l;
  assign cur_wd   = idle ? wdata_s : wdata_l;
  assign cur_cnt  = idle ? 3'd0 : cnt;
  assign baddr    = cur_addr + ADDR_W'(cur_cnt);
  assign io       = (baddr[IO_LSB+1:IO_LSB] == IO_REG);

  assign abort = (state == XFER) & ~we_l
               & (~req_g | (addr_g != addr_l));
  assign issue = ((idle & any) | ((state == XFER) & (cnt < n_l)))
               & ~abort;
  assign stall   = cur_we & io & io_buffer_full;
  assign fire    = issue & ~stall;
  assign last    = (cur_cnt == cur_n - 3'd1);
  assign wr_last = fire & cur_we & last;
  assign dsel    = idle ? sel : g;
  assign busy    = (state != IDLE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (any) state_n = wr_last ? DONE : XFER;
      XFER: begin
        if (abort)                 state_n = IDLE;
        else if (wr_last | rd_fin) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    for (int p = 0; p < NPORT; p++)
      done_n[p] = (wr_last | rd_fin) & (dsel == 3'(p));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      g        <= '0;
      cnt      <= '0;
      we_l     <= 1'b0;
      sz_l     <= '0;
      sext_l   <= 1'b0;
      addr_l   <= '0;
      wdata_l  <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      mem_wr   <= 1'b0;
      done     <= '0;
    end else begin
      state  <= state_n;
      done   <= done_n;
      mem_wr <= fire & cur_we;
      if (idle && any) begin
        g       <= sel;
        we_l    <= we_s;
        sz_l    <= size_s[1:0];
        sext_l  <= size_s[2];
        addr_l  <= addr_s;
        wdata_l <= wdata_s;
      end
      if (fire)      cnt <= cur_cnt + 3'd1;
      else if (idle) cnt <= '0;
      if (fire) begin
        mem_a <= baddr;
        if (cur_we) mem_dout <= cur_wd[{cur_cnt[1:0], 3'b000} +: 8];
      end
    end
  end

  mem_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (fire & ~cur_we),
    .push_idx  (cur_cnt[1:0]),
    .push_last (last),
    .sz        (sz_l),
    .sext      (sext_l),
    .mem_din   (mem_din),
    .fin       (rd_fin),
    .rdata     (rdata)
  );

endmodule

// File: tb/tb_mem_ctrl_mp.sv
// Bench for mem_ctrl_mp: vector table, directed corner sequences
// and a randomized multi-port run against a byte-array model.
module tb_mem_ctrl_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, we, done;
  logic [8:0]  size;
  logic [95:0] addr, wdata;
  logic [31:0] rdata, mem_a, a_d1;
  logic        busy, mem_wr, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_ctrl_mp #(
    .ADDR_W(32), .NPORT(3), .RD_LAT(2), .IO_LSB(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
    .busy(busy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  // RAM environment: byte store, data returned RD_LAT=2 edges after mem_a
  logic [7:0] ram [logic [31:0]];
  logic [7:0] mdl [logic [31:0]];

  function automatic logic [7:0] deflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return deflt(a);
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    if (mdl.exists(a)) return mdl[a];
    return deflt(a);
  endfunction

  always @(posedge clk) begin
    a_d1 <= mem_a;
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  always @(negedge clk) mem_din = ram_rd(a_d1);

  function automatic int nb(input logic [2:0] sz);
    return (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a,
                                           input logic [2:0] sz);
    logic [63:0] v;
    int n;
    n = nb(sz);
    v = '0;
    for (int i = 0; i < n; i++)
      v |= 64'(mdl_rd(a + 32'(i))) << (8 * i);
    if (sz[2] && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
    return v[31:0];
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v |= 32'(ram_rd(a + 32'(i))) << (8 * i);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    else
      n_pass++;
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s (no response within bound)", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) ram[a + 32'(i)] = d[8*i +: 8];
  endtask

  task automatic drive(input int p, input logic w, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    we[p]          = w;
    size[3*p +: 3] = sz;
    addr[32*p +: 32]  = a;
    wdata[32*p +: 32] = wd;
  endtask

  task automatic run_txn(input int p, input logic w, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output int nwr,
                         output logic [31:0] rd);
    lat = -1;
    nwr = 0;
    rd  = '0;
    drive(p, w, sz, a, wd);
    req[p] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (mem_wr) nwr++;
      if (done[p]) begin
        lat = k - 1;
        rd  = rdata;
        break;
      end
    end
    req[p] = 1'b0;
    repeat (2) tick();
  endtask

  typedef struct {
    int          p;
    logic        w;
    logic [2:0]  sz;
    logic [31:0] a;
    logic        pre;
    logic [31:0] d;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tv[10];

  initial begin
    int lat, nwr, d0, d2, nw, dk, stallwr, nw_done;
    logic [31:0] rd, a0, r2, dat;
    logic [31:0] wa [8];
    logic [7:0]  wdv [8];
    logic [2:0]  p_sz [3];
    logic [31:0] p_a [3], p_wd [3];
    logic        p_we [3];
    int          age [3], gap [3];
    logic        full_prev, drain;

    tv[0] = '{1, 1'b0, 3'b010, 32'h100,      1'b1, 32'h44332211, 32'h44332211, 5};
    tv[1] = '{0, 1'b0, 3'b101, 32'h40,       1'b1, 32'h0000FF80, 32'hFFFFFF80, 3};
    tv[2] = '{0, 1'b0, 3'b001, 32'h40,       1'b1, 32'h0000FF80, 32'h0000FF80, 3};
    tv[3] = '{2, 1'b0, 3'b100, 32'h50,       1'b1, 32'h000000F0, 32'hFFFFFFF0, 2};
    tv[4] = '{2, 1'b0, 3'b100, 32'h51,       1'b1, 32'h0000007F, 32'h0000007F, 2};
    tv[5] = '{1, 1'b0, 3'b111, 32'h103,      1'b1, 32'h8899AABB, 32'h8899AABB, 5};
    tv[6] = '{0, 1'b1, 3'b000, 32'h300,      1'b0, 32'hDEADBEEF, 32'h000000EF, 0};
    tv[7] = '{1, 1'b1, 3'b001, 32'h310,      1'b0, 32'h12345678, 32'h00005678, 1};
    tv[8] = '{2, 1'b1, 3'b010, 32'hFFFFFFFE, 1'b0, 32'h04030201, 32'h04030201, 3};
    tv[9] = '{0, 1'b0, 3'b010, 32'hFFFFFFFE, 1'b0, 32'h0,        32'h04030201, 5};

    rst = 1'b1;
    req = '0;
    we = '0;
    size = '0;
    addr = '0;
    wdata = '0;
    io_buffer_full = 1'b0;
    repeat (3) tick();
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_dout", 32'(mem_dout), 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();

    // vector table
    for (int i = 0; i < 10; i++) begin
      if (tv[i].pre) set_word(tv[i].a, tv[i].d);
      run_txn(tv[i].p, tv[i].w, tv[i].sz, tv[i].a, tv[i].d, lat, nwr, rd);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tv[i].lat));
      if (tv[i].w) begin
        chk($sformatf("vec%0d_ram", i), ram_word(tv[i].a, nb(tv[i].sz)),
            tv[i].exp);
        chk($sformatf("vec%0d_nwr", i), 32'(nwr), 32'(nb(tv[i].sz)));
      end else begin
        chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp);
        chk($sformatf("vec%0d_nwr", i), 32'(nwr), 32'h0);
      end
    end

    // port0 byte write and port2 byte read at the same time
    drive(0, 1'b1, 3'b000, 32'h200, 32'h000000A5);
    drive(2, 1'b0, 3'b000, 32'h200, 32'h0);
    req = 3'b101;
    d0 = -1; d2 = -1; nw = 0; a0 = '0; r2 = '0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (mem_wr && mem_a == 32'h200) nw++;
      if (done[0]) begin d0 = k; a0 = mem_a; req[0] = 1'b0; end
      if (done[2]) begin d2 = k; r2 = rdata; req[2] = 1'b0; end
      if (d0 >= 0 && d2 >= 0) break;
    end
    req = '0;
    repeat (2) tick();
    chk("prio_p0_done_at_grant", 32'(d0), 32'd1);
    chk("prio_p2_after_p0", 32'(d2 - d0), 32'd4);
    chk("prio_wr_pulses", 32'(nw), 32'd1);
    chk("prio_wr_addr", a0, 32'h200);
    chk("prio_p2_rdata", r2, 32'h000000A5);

    // read abort by address change, then retry from the new address
    set_word(32'h1000, 32'hA4A3A2A1);
    set_word(32'h1004, 32'hB4B3B2B1);
    drive(2, 1'b0, 3'b010, 32'h1000, 32'h0);
    req[2] = 1'b1;
    nw = 0; dk = -1; r2 = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 2) addr[64 +: 32] = 32'h1004;
      if (done[2]) begin
        nw++;
        if (dk < 0) begin dk = k; r2 = rdata; end
        req[2] = 1'b0;
      end
    end
    chk("abort_done_count", 32'(nw), 32'd1);
    chk("abort_retry_rdata", r2, 32'hB4B3B2B1);
    chk("abort_retry_latency", 32'(dk - 1), 32'd8);

    // IO write held off by io_buffer_full
    drive(0, 1'b1, 3'b010, 32'h30000, 32'h0D0C0B0A);
    io_buffer_full = 1'b1;
    req[0] = 1'b1;
    nw = 0; stallwr = 0; dk = -1; nw_done = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (mem_wr) begin
        if (k <= 3) stallwr++;
        if (nw < 8) begin wa[nw] = mem_a; wdv[nw] = mem_dout; end
        nw++;
      end
      if (k == 3) io_buffer_full = 1'b0;
      if (done[0]) begin dk = k; nw_done = nw; req[0] = 1'b0; break; end
    end
    io_buffer_full = 1'b0;
    req = '0;
    repeat (2) tick();
    chk("io_no_wr_while_full", 32'(stallwr), 32'd0);
    chk("io_done_on_4th", 32'(nw_done), 32'd4);
    chk("io_done_cycle", 32'(dk - 1), 32'd6);
    for (int i = 0; i < 4; i++)
      chk($sformatf("io_addr%0d", i), (nw > i) ? wa[i] : 32'hX,
          32'h30000 + 32'(i));
    dat = '0;
    for (int i = 0; i < 4 && i < nw; i++) dat |= 32'(wdv[i]) << (8 * i);
    chk("io_data", dat, 32'h0D0C0B0A);

    // reset in the middle of a word write
    drive(1, 1'b1, 3'b010, 32'h400, 32'h44434241);
    req[1] = 1'b1;
    nw = 0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      if (mem_wr) nw++;
    end
    chk("rstmid_two_bytes", 32'(nw), 32'd2);
    rst = 1'b1;
    tick();
    chk("rstmid_mem_wr", 32'(mem_wr), 32'h0);
    chk("rstmid_done", 32'(done), 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    req = '0;
    rst = 1'b0;
    nw = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (mem_wr || done != 0) nw++;
    end
    chk("rstmid_quiet", 32'(nw), 32'd0);
    chk("rstmid_byte0", 32'(ram_rd(32'h400)), 32'h41);
    chk("rstmid_byte2_untouched", 32'(ram_rd(32'h402)),
        32'(deflt(32'h402)));

    // randomized traffic on all ports against the byte model
    for (int p = 0; p < 3; p++) begin
      age[p] = 0;
      gap[p] = $urandom_range(0, 3);
      p_we[p] = 1'b0; p_sz[p] = '0; p_a[p] = '0; p_wd[p] = '0;
    end
    full_prev = 1'b0;
    drain = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      if (cyc == 3500) drain = 1'b1;
      chk("rnd_done_onehot", 32'($onehot0(done)), 32'd1);
      chk("rnd_done_has_req", 32'(done & ~req), 32'h0);
      if (mem_wr) chk("rnd_wr_busy", 32'(busy), 32'd1);
      if (mem_wr && mem_a[17:16] == 2'b11)
        chk("rnd_io_stall", 32'(full_prev), 32'd0);
      for (int p = 0; p < 3; p++) begin
        if (req[p]) begin
          age[p]++;
          if (done[p]) begin
            if (!p_we[p])
              chk($sformatf("rnd_rd_p%0d", p), rdata,
                  mdl_read(p_a[p], p_sz[p]));
            else
              for (int i = 0; i < nb(p_sz[p]); i++)
                mdl[p_a[p] + 32'(i)] = p_wd[p][8*i +: 8];
            req[p] = 1'b0;
            gap[p] = $urandom_range(2, 8);
          end else if (age[p] > 400) begin
            fail_now($sformatf("rnd_timeout_p%0d", p));
            req[p] = 1'b0;
            gap[p] = 2;
          end
        end else if (!drain) begin
          if (gap[p] > 0) gap[p]--;
          else begin
            p_we[p] = 1'($urandom_range(0, 1));
            p_sz[p] = 3'($urandom_range(0, 7));
            p_a[p]  = ($urandom_range(0, 3) == 0)
                    ? 32'h38000 + 32'($urandom_range(0, 15))
                    : 32'h8000 + 32'($urandom_range(0, 63));
            p_wd[p] = $urandom;
            drive(p, p_we[p], p_sz[p], p_a[p], p_wd[p]);
            req[p] = 1'b1;
            age[p] = 0;
          end
        end
      end
      io_buffer_full = ($urandom_range(0, 3) == 0);
      full_prev = io_buffer_full;
    end
    io_buffer_full = 1'b0;
    chk("rnd_drained", 32'(req), 32'h0);
    foreach (mdl[a]) chk("rnd_mem", 32'(ram_rd(a)), 32'(mdl[a]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
